// File: rtl/pgm_gfx_ddram_bridge.sv
// Graphics-ROM read responder and ROM-download word packer on the MiSTer DDRAM Avalon-MM port.
// Define PGM_GFX_LINE_CACHE_EN to add a single-line cache of the last DDR read.
module pgm_gfx_ddram_bridge #(
    parameter logic [28:0] BASE_ADDR = 29'h0600000,
    parameter int          DL_ADDR_W = 27
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_rd,
    input  logic [28:0]          req_addr,
    output logic                 req_busy,
    output logic [63:0]          req_dout,
    output logic                 req_dout_ready,
    input  logic                 dl_wr,
    input  logic [DL_ADDR_W-1:0] dl_addr,
    input  logic [15:0]          dl_data,
    input  logic                 dl_flush,
    output logic                 dl_busy,
    input  logic                 ddr_busy,
    output logic [28:0]          ddr_addr,
    output logic [7:0]           ddr_burstcnt,
    output logic                 ddr_rd,
    output logic                 ddr_we,
    output logic [63:0]          ddr_din,
    output logic [7:0]           ddr_be,
    input  logic [63:0]          ddr_dout,
    input  logic                 ddr_dout_ready
);
    // IDLE wait | RD_ISSUE read cmd out | RD_WAIT await beat | WR_ISSUE pack write out | HIT cached line
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, HIT} state_t;

    state_t               state;
    logic [63:0]          pack, pack_nxt;
    logic [3:0]           mask, mask_nxt;
    logic [DL_ADDR_W-4:0] pack_addr, pack_addr_nxt;
    logic [7:0]           be_nxt;
    logic [1:0]           lane;
    logic                 wr_pend, wr_set, dl_take, hit;
    logic                 unused_dl_addr;

`ifdef PGM_GFX_LINE_CACHE_EN
    logic [28:0] tag;
    logic        valid;
    assign hit = valid && (tag == req_addr);
`else
    assign hit = 1'b0;
`endif

    assign unused_dl_addr = dl_addr[0];
    assign lane           = dl_addr[2:1];
    assign dl_take        = dl_wr && !wr_pend;
    assign ddr_burstcnt   = 8'd1;
    assign dl_busy        = wr_pend;
    assign req_busy       = (state != IDLE) || wr_pend;

    // Next pack contents include this cycle's word so a write that becomes pending now wins over a read.
    always_comb begin
        pack_nxt      = pack;
        mask_nxt      = mask;
        pack_addr_nxt = pack_addr;
        be_nxt        = 8'd0;
        if (dl_take) begin
            pack_nxt[{lane, 4'b0000} +: 16] = dl_data;
            mask_nxt[lane]                  = 1'b1;
            pack_addr_nxt                   = dl_addr[DL_ADDR_W-1:3];
        end
        wr_set = !wr_pend && ((dl_take && lane == 2'd3) || (dl_flush && mask_nxt != 4'd0));
        for (int i = 0; i < 4; i++) be_nxt[2*i +: 2] = {2{mask_nxt[i]}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ddr_rd         <= 1'b0;
            ddr_we         <= 1'b0;
            req_dout_ready <= 1'b0;
            req_dout       <= '0;
            ddr_addr       <= '0;
            ddr_din        <= '0;
            ddr_be         <= '0;
            pack           <= '0;
            mask           <= '0;
            pack_addr      <= '0;
            wr_pend        <= 1'b0;
`ifdef PGM_GFX_LINE_CACHE_EN
            tag            <= '0;
            valid          <= 1'b0;
`endif
        end else begin
            req_dout_ready <= 1'b0;
            pack           <= pack_nxt;
            mask           <= mask_nxt;
            pack_addr      <= pack_addr_nxt;
            if (wr_set) wr_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (wr_pend || wr_set) begin
                        ddr_we   <= 1'b1;
                        ddr_addr <= BASE_ADDR + 29'(pack_addr_nxt);
                        ddr_din  <= pack_nxt;
                        ddr_be   <= be_nxt;
                        state    <= WR_ISSUE;
`ifdef PGM_GFX_LINE_CACHE_EN
                        if (tag == 29'(pack_addr_nxt)) valid <= 1'b0;
`endif
                    end else if (req_rd && !req_dout_ready) begin
                        // The ready-pulse cycle still sees the old request held high; skip it.
                        if (hit) begin
                            state <= HIT;
                        end else begin
                            ddr_addr <= BASE_ADDR + req_addr;
                            ddr_rd   <= 1'b1;
                            state    <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (!ddr_busy) begin
                        ddr_rd <= 1'b0;
                        state  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (ddr_dout_ready) begin
                        req_dout       <= ddr_dout;
                        req_dout_ready <= 1'b1;
                        state          <= IDLE;
`ifdef PGM_GFX_LINE_CACHE_EN
                        tag            <= ddr_addr - BASE_ADDR;
                        valid          <= 1'b1;
`endif
                    end
                end
                WR_ISSUE: begin
                    if (!ddr_busy) begin
                        ddr_we  <= 1'b0;
                        pack    <= '0;
                        mask    <= '0;
                        wr_pend <= 1'b0;
                        state   <= IDLE;
                    end
                end
                HIT: begin
                    req_dout_ready <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pgm_gfx_ddram_bridge.sv
// Bench for pgm_gfx_ddram_bridge: DDR responder model, scoreboard queues, directed and random traffic.
`timescale 1ns/1ps
module tb_pgm_gfx_ddram_bridge;
    localparam logic [28:0] BASE = 29'h0600000;

    logic        clk = 1'b0, reset = 1'b1;
    logic        req_rd = 1'b0;
    logic [28:0] req_addr = '0;
    logic        req_busy;
    logic [63:0] req_dout;
    logic        req_dout_ready;
    logic        dl_wr = 1'b0;
    logic [26:0] dl_addr = '0;
    logic [15:0] dl_data = '0;
    logic        dl_flush = 1'b0;
    logic        dl_busy;
    logic        ddr_busy = 1'b0;
    logic [28:0] ddr_addr;
    logic [7:0]  ddr_burstcnt;
    logic        ddr_rd, ddr_we;
    logic [63:0] ddr_din;
    logic [7:0]  ddr_be;
    logic [63:0] ddr_dout = '0;
    logic        ddr_dout_ready = 1'b0;

    pgm_gfx_ddram_bridge dut (
        .clk(clk), .reset(reset),
        .req_rd(req_rd), .req_addr(req_addr), .req_busy(req_busy),
        .req_dout(req_dout), .req_dout_ready(req_dout_ready),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_flush(dl_flush), .dl_busy(dl_busy),
        .ddr_busy(ddr_busy), .ddr_addr(ddr_addr), .ddr_burstcnt(ddr_burstcnt),
        .ddr_rd(ddr_rd), .ddr_we(ddr_we), .ddr_din(ddr_din), .ddr_be(ddr_be),
        .ddr_dout(ddr_dout), .ddr_dout_ready(ddr_dout_ready)
    );

    always #5 clk = ~clk;

    typedef struct {int due; logic [63:0] data;} rsp_t;
    typedef struct {logic [28:0] addr; logic [63:0] din; logic [7:0] be;} wr_t;

    int checks = 0, errors = 0, cyc = 0;
    rsp_t        rsp_q[$];
    wr_t         exp_wr[$];
    logic [63:0] exp_data[$];
    logic [28:0] exp_rd_addr[$];

    int  lat_fixed = 4, busy_hold = 0;
    bit  busy_rand = 0, fixed_en = 0;
    logic [63:0] fixed_data = 64'h0123456789ABCDEF;
    int  rd_acc = 0, wr_acc = 0, ready_cnt = 0, rd_acc_cyc = 0, wr_acc_cyc = 0, rd_high = 0, rd_len = 0;
    logic [28:0] rd_hold = '0;

    logic [63:0] m_din = '0;
    logic [7:0]  m_be = '0;
    logic [28:0] m_waddr = '0;
`ifdef PGM_GFX_LINE_CACHE_EN
    bit          c_valid = 0;
    logic [28:0] c_tag = '0;
`endif

    function automatic logic [63:0] mem_word(input logic [28:0] a);
        return {a[15:0] ^ 16'h5A5A, 3'b101, a, ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not as required", name);
    endtask

    // DDR responder and output monitor; drives DDR inputs mid-cycle.
    always @(negedge clk) begin
        wr_t  w;
        rsp_t r;
        cyc++;
        if (req_dout_ready) begin
            ready_cnt++;
            if (exp_data.size() == 0) fail("unexpected_ready");
            else chk("rd_data", req_dout, exp_data.pop_front());
        end
        ddr_dout_ready = 1'b0;
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            ddr_dout       = rsp_q[0].data;
            ddr_dout_ready = 1'b1;
            rsp_q.delete(0);
        end
        if (busy_hold > 0 && (ddr_rd || ddr_we)) begin
            ddr_busy = 1'b1;
            busy_hold--;
        end else begin
            ddr_busy = busy_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        if (ddr_rd) begin
            rd_high++;
            if (rd_high > 1) chk("rd_addr_stable", ddr_addr, rd_hold);
            chk("req_busy_during_rd", req_busy, 1);
            rd_hold = ddr_addr;
            if (!ddr_busy) begin
                rd_acc++;
                rd_acc_cyc = cyc;
                rd_len     = rd_high;
                if (exp_rd_addr.size() == 0) fail("unexpected_ddr_rd");
                else chk("ddr_rd_addr", ddr_addr, exp_rd_addr.pop_front());
                r.due  = cyc + (lat_fixed > 0 ? lat_fixed : int'($urandom_range(1, 6)));
                r.data = fixed_en ? fixed_data : mem_word(ddr_addr);
                rsp_q.push_back(r);
            end
        end else begin
            rd_high = 0;
        end
        if (ddr_we) begin
            chk("dl_busy_during_wr", dl_busy, 1);
            if (!ddr_busy) begin
                wr_acc++;
                wr_acc_cyc = cyc;
                if (exp_wr.size() == 0) fail("unexpected_ddr_we");
                else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", ddr_addr, w.addr);
                    chk("wr_din", ddr_din, w.din);
                    chk("wr_be", ddr_be, w.be);
                end
            end
        end
    end

    task automatic model_emit();
        wr_t w;
        w.addr = BASE + m_waddr;
        w.din  = m_din;
        w.be   = m_be;
        exp_wr.push_back(w);
`ifdef PGM_GFX_LINE_CACHE_EN
        if (c_valid && c_tag == m_waddr) c_valid = 0;
`endif
        m_din = '0;
        m_be  = '0;
    endtask

    task automatic model_dl(input logic [26:0] a, input logic [15:0] d);
        int ln = int'(a[2:1]);
        m_din   = (m_din & ~(64'hFFFF << (16 * ln))) | (64'(d) << (16 * ln));
        m_be    = m_be | (8'h03 << (2 * ln));
        m_waddr = 29'(a >> 3);
        if (ln == 3) model_emit();
    endtask

    task automatic start_read(input logic [28:0] a, input logic [63:0] d);
        logic [28:0] phys = BASE + a;
        exp_data.push_back(d);
`ifdef PGM_GFX_LINE_CACHE_EN
        if (!(c_valid && c_tag == a)) exp_rd_addr.push_back(phys);
        c_valid = 1;
        c_tag   = a;
`else
        exp_rd_addr.push_back(phys);
`endif
        req_addr = a;
        req_rd   = 1'b1;
    endtask

    task automatic finish_read(output int k);
        k = 0;
        while (k < 200 && !req_dout_ready) begin
            @(negedge clk);
            k++;
        end
        if (!req_dout_ready) fail("rd_timeout");
        @(posedge clk);
        #1 req_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [28:0] a);
        int k;
        logic [28:0] phys = BASE + a;
        @(negedge clk);
        start_read(a, mem_word(phys));
        finish_read(k);
    endtask

    task automatic dl_word(input logic [26:0] a, input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        while (dl_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (dl_busy) fail("dl_busy_timeout");
        model_dl(a, d);
        dl_addr = a;
        dl_data = d;
        dl_wr   = 1'b1;
        @(negedge clk);
        dl_wr = 1'b0;
    endtask

    task automatic flush();
        @(negedge clk);
        dl_flush = 1'b1;
        if (m_be != 0) model_emit();
        @(negedge clk);
        dl_flush = 1'b0;
    endtask

    task automatic wait_dl_idle();
        int n = 0;
        while ((dl_busy || exp_wr.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (dl_busy || exp_wr.size() != 0) fail("wr_timeout");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, r0, w0, c0;
        logic [28:0] a;
        logic [26:0] ba;
        repeat (3) @(negedge clk);
        chk("rst_ddr_rd", ddr_rd, 0);
        chk("rst_ddr_we", ddr_we, 0);
        chk("rst_ready", req_dout_ready, 0);
        chk("rst_req_dout", req_dout, 0);
        chk("rst_ddr_addr", ddr_addr, 0);
        chk("rst_ddr_din", ddr_din, 0);
        chk("rst_ddr_be", ddr_be, 0);
        chk("rst_dl_busy", dl_busy, 0);
        chk("rst_req_busy", req_busy, 0);
        chk("burstcnt", ddr_burstcnt, 1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // single read, fixed 4-cycle DDR latency
        lat_fixed = 4;
        fixed_en  = 1;
        @(negedge clk);
        start_read(29'd5, 64'h0123456789ABCDEF);
        finish_read(k);
        chk("t1_latency", k, 6);
        chk("t1_rd_len", rd_len, 1);
        fixed_en = 0;

        // waitrequest held for 3 cycles
        busy_hold = 3;
        r0 = rd_acc;
        do_read(29'd9);
        chk("t2_rd_len", rd_len, 4);
        chk("t2_one_read", rd_acc - r0, 1);

        // full pack of four words
        busy_hold = 2;
        w0 = wr_acc;
        dl_word(27'd0, 16'h1111);
        dl_word(27'd2, 16'h2222);
        dl_word(27'd4, 16'h3333);
        dl_word(27'd6, 16'h4444);
        chk("t3_dl_busy", dl_busy, 1);
        wait_dl_idle();
        chk("t3_one_write", wr_acc - w0, 1);

        // single word then flush
        dl_word(27'h0A, 16'hABCD);
        flush();
        wait_dl_idle();

        // read request in the same cycle the pack fills
        dl_word(27'd16, 16'hA001);
        dl_word(27'd18, 16'hA002);
        dl_word(27'd20, 16'hA003);
        model_dl(27'd22, 16'hA004);
        dl_addr = 27'd22;
        dl_data = 16'hA004;
        dl_wr   = 1'b1;
        a = BASE + 29'd3;
        start_read(29'd3, mem_word(a));
        @(negedge clk);
        dl_wr = 1'b0;
        finish_read(k);
        wait_dl_idle();
        chk("t5_wr_first", wr_acc_cyc < rd_acc_cyc, 1);

        // reset in RD_WAIT with a stale beat afterwards; partial pack discarded
        dl_word(27'h40, 16'hBEEF);
        lat_fixed = 8;
        @(negedge clk);
        r0 = rd_acc;
        a = BASE + 29'd11;
        start_read(29'd11, mem_word(a));
        k = 0;
        while (rd_acc == r0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (rd_acc == r0) fail("t6_rd_not_issued");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        req_rd = 1'b0;
        exp_data.delete();
        m_din = '0;
        m_be  = '0;
`ifdef PGM_GFX_LINE_CACHE_EN
        c_valid = 0;
`endif
        c0 = ready_cnt;
        w0 = wr_acc;
        chk("t6_rd_dropped", ddr_rd, 0);
        flush();
        repeat (12) @(negedge clk);
        chk("t6_no_stale_ready", ready_cnt, c0);
        chk("t6_pack_discarded", wr_acc, w0);
        chk("t6_req_busy", req_busy, 0);
        chk("t6_dl_busy", dl_busy, 0);

`ifdef PGM_GFX_LINE_CACHE_EN
        // line cache: repeat read hits, write to same word invalidates
        lat_fixed = 3;
        r0 = rd_acc;
        do_read(29'd7);
        a = BASE + 29'd7;
        @(negedge clk);
        start_read(29'd7, mem_word(a));
        finish_read(k);
        chk("t7_hit_latency", k, 2);
        chk("t7_one_ddr_read", rd_acc - r0, 1);
        dl_word(27'd56, 16'h0707);
        dl_word(27'd58, 16'h1717);
        dl_word(27'd60, 16'h2727);
        dl_word(27'd62, 16'h3737);
        wait_dl_idle();
        r0 = rd_acc;
        do_read(29'd7);
        chk("t7_refetch", rd_acc - r0, 1);
`endif

        // randomized mix of reads and downloads with random waitrequest and latency
        lat_fixed = 0;
        busy_rand = 1;
        for (int op = 0; op < 60; op++) begin
            if ($urandom_range(0, 1) == 0) begin
                if ($urandom_range(0, 9) == 0) a = 29'h1FFFFFFF - 29'($urandom_range(0, 3));
                else a = 29'($urandom_range(0, 7));
                do_read(a);
            end else begin
                k = int'($urandom_range(1, 4));
                w0 = int'($urandom_range(0, 7));
                for (int i = 0; i < k; i++) begin
                    ba = 27'(w0 * 8 + int'($urandom_range(0, 3)) * 2);
                    dl_word(ba, 16'($urandom));
                end
                flush();
                wait_dl_idle();
            end
        end
        busy_rand = 0;
        repeat (20) @(negedge clk);
        chk("end_rd_data_q", exp_data.size(), 0);
        chk("end_rd_addr_q", exp_rd_addr.size(), 0);
        chk("end_wr_q", exp_wr.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
